// File: rtl/spi_mem_ctrl.sv
// Host-side SPI master for the 32x8 SPI memory slave: one word per request, LSB first, owns slave reset.
// Optional feature: define SPI_MEM_CTRL_TIMEOUT_EN to abort a stalled WAIT after TIMEOUT cycles.
module spi_mem_ctrl #(
    parameter int unsigned TIMEOUT = 32
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic       req_write,
    input  logic [4:0] req_addr,
    input  logic [7:0] req_wdata,
    output logic       rsp_valid,
    output logic [7:0] rsp_rdata,
    output logic       rsp_err,
    output logic       cs_n,
    output logic       sdo,
    input  logic       sdi,
    input  logic       s_ready,
    input  logic       s_op_done,
    output logic       s_rst,
    output logic [2:0] dbg_state
);

    // Host handshake: a request transfers on a clk edge with req_valid && req_ready; req_ready is
    // high only in IDLE and req_* are ignored after the transfer. rsp_valid is a one-cycle strobe, no back-pressure.
    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_CMD     = 3'd1;
    localparam logic [2:0] ST_SHIFT   = 3'd2;
    localparam logic [2:0] ST_WAIT    = 3'd3;
    localparam logic [2:0] ST_CAPTURE = 3'd4;
    localparam logic [2:0] ST_RECOVER = 3'd5;

    logic [2:0]  state;
    logic [15:0] frame;
    logic        is_write;
    logic [3:0]  bit_cnt;
    logic [3:0]  last_bit;
    logic [7:0]  cap;

`ifdef SPI_MEM_CTRL_TIMEOUT_EN
    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);
    logic [7:0] wait_cnt;
    logic       timed_out;
    logic       rsp_err_q;
    assign rsp_err = rsp_err_q;
`else
    assign rsp_err = 1'b0;
`endif

    assign dbg_state = state;
    assign last_bit  = is_write ? 4'd15 : 4'd7;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            cs_n      <= 1'b1;
            sdo       <= 1'b0;
            s_rst     <= 1'b1;
            req_ready <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_rdata <= 8'h00;
            frame     <= 16'h0000;
            is_write  <= 1'b0;
            bit_cnt   <= 4'd0;
            cap       <= 8'h00;
`ifdef SPI_MEM_CTRL_TIMEOUT_EN
            wait_cnt  <= 8'd0;
            timed_out <= 1'b0;
            rsp_err_q <= 1'b0;
`endif
        end else begin
            rsp_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    s_rst <= 1'b0;
                    if (req_valid && req_ready) begin
                        req_ready <= 1'b0;
                        is_write  <= req_write;
                        frame     <= req_write ? {req_wdata, 3'b000, req_addr}
                                               : {8'h00, 3'b000, req_addr};
                        cs_n      <= 1'b0;
                        sdo       <= req_write;
                        bit_cnt   <= 4'd0;
                        state     <= ST_CMD;
                    end else begin
                        req_ready <= 1'b1;
                    end
                end
                // op stays on sdo for two cycles: slave sees select, then samples op
                ST_CMD: begin
                    if (bit_cnt == 4'd1) begin
                        sdo     <= frame[0];
                        frame   <= {1'b0, frame[15:1]};
                        bit_cnt <= 4'd0;
                        state   <= ST_SHIFT;
                    end else begin
                        bit_cnt <= bit_cnt + 4'd1;
                    end
                end
                ST_SHIFT: begin
                    if (bit_cnt == last_bit) begin
                        cs_n  <= 1'b1;
                        sdo   <= 1'b0;
                        state <= ST_WAIT;
`ifdef SPI_MEM_CTRL_TIMEOUT_EN
                        wait_cnt <= 8'd0;
`endif
                    end else begin
                        sdo     <= frame[0];
                        frame   <= {1'b0, frame[15:1]};
                        bit_cnt <= bit_cnt + 4'd1;
                    end
                end
                ST_WAIT: begin
                    if (is_write && s_op_done) begin
                        rsp_valid <= 1'b1;
                        rsp_rdata <= 8'h00;
                        req_ready <= 1'b1;
                        state     <= ST_IDLE;
`ifdef SPI_MEM_CTRL_TIMEOUT_EN
                        rsp_err_q <= 1'b0;
`endif
                    end else if (!is_write && s_ready) begin
                        bit_cnt <= 4'd0;
                        state   <= ST_CAPTURE;
                    end
`ifdef SPI_MEM_CTRL_TIMEOUT_EN
                    else if (wait_cnt == WAIT_LAST) begin
                        s_rst     <= 1'b1;
                        timed_out <= 1'b1;
                        state     <= ST_RECOVER;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
`endif
                end
                ST_CAPTURE: begin
                    cap     <= {sdi, cap[7:1]};
                    bit_cnt <= bit_cnt + 4'd1;
                    // slave parks after a read; pulse its reset while the last bit lands
                    if (bit_cnt == 4'd7) begin
                        s_rst <= 1'b1;
                        state <= ST_RECOVER;
                    end
                end
                ST_RECOVER: begin
                    s_rst     <= 1'b0;
                    rsp_valid <= 1'b1;
                    req_ready <= 1'b1;
                    state     <= ST_IDLE;
`ifdef SPI_MEM_CTRL_TIMEOUT_EN
                    rsp_rdata <= timed_out ? 8'h00 : cap;
                    rsp_err_q <= timed_out;
                    timed_out <= 1'b0;
`else
                    rsp_rdata <= cap;
`endif
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_mem_ctrl.sv
// Directed bench for spi_mem_ctrl with a behavioural model of the 32x8 SPI memory slave.
// Covers frame timing, read/write latency, back-to-back, reset mid-transfer and the WAIT timeout.
module tb_spi_mem_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       req_valid = 1'b0;
    logic       req_ready;
    logic       req_write = 1'b0;
    logic [4:0] req_addr = 5'd0;
    logic [7:0] req_wdata = 8'h00;
    logic       rsp_valid;
    logic [7:0] rsp_rdata;
    logic       rsp_err;
    logic       cs_n;
    logic       sdo;
    logic       sdi = 1'b0;
    logic       s_ready;
    logic       s_op_done;
    logic       s_rst;
    logic [2:0] dbg_state;
    logic       stub_done = 1'b0;

    int checks = 0;
    int failures = 0;

    spi_mem_ctrl #(.TIMEOUT(32)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .cs_n(cs_n), .sdo(sdo), .sdi(sdi), .s_ready(s_ready), .s_op_done(s_op_done),
        .s_rst(s_rst), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    // ---------------- slave model ----------------
    localparam int SL_IDLE = 0, SL_OP = 1, SL_ADDR = 2, SL_DATA = 3, SL_DONE = 4,
                   SL_DONE2 = 5, SL_RDY = 6, SL_RDY2 = 7, SL_SEND = 8, SL_PARK = 9;
    int         sl_st = SL_IDLE;
    int         sl_cnt = 0;
    logic       sl_op = 1'b0;
    logic [7:0] sl_addr = 8'h00;
    logic [7:0] sl_data = 8'h00;
    logic       sl_done = 1'b0;
    logic       sl_rdy = 1'b0;
    logic [7:0] mem [32];

    initial for (int i = 0; i < 32; i++) mem[i] = 8'(i) ^ 8'h5A;

    assign s_op_done = sl_done & ~stub_done;
    assign s_ready   = sl_rdy;

    always @(posedge clk) begin
        if (s_rst) begin
            sl_st <= SL_IDLE; sl_done <= 1'b0; sl_rdy <= 1'b0; sdi <= 1'b0; sl_cnt <= 0;
        end else begin
            case (sl_st)
                SL_IDLE: if (!cs_n) sl_st <= SL_OP;
                SL_OP:   begin sl_op <= sdo; sl_cnt <= 0; sl_st <= SL_ADDR; end
                SL_ADDR: begin
                    sl_addr[sl_cnt] <= sdo;
                    sl_cnt <= sl_cnt + 1;
                    if (sl_cnt == 7) begin sl_cnt <= 0; sl_st <= sl_op ? SL_DATA : SL_RDY; end
                end
                SL_DATA: begin
                    sl_data[sl_cnt] <= sdo;
                    sl_cnt <= sl_cnt + 1;
                    if (sl_cnt == 7) begin mem[sl_addr[4:0]] <= {sdo, sl_data[6:0]}; sl_st <= SL_DONE; end
                end
                SL_DONE:  begin sl_done <= 1'b1; sl_st <= SL_DONE2; end
                SL_DONE2: begin sl_done <= 1'b0; sl_st <= SL_IDLE; end
                SL_RDY:   begin sl_rdy <= 1'b1; sl_st <= SL_RDY2; end
                SL_RDY2:  begin sl_rdy <= 1'b0; sdi <= mem[sl_addr[4:0]][0]; sl_cnt <= 1; sl_st <= SL_SEND; end
                SL_SEND: begin
                    if (sl_cnt == 8) begin sdi <= 1'b0; sl_st <= SL_PARK; end
                    else begin sdi <= mem[sl_addr[4:0]][sl_cnt]; sl_cnt <= sl_cnt + 1; end
                end
                default: ;
            endcase
        end
    end

    // ---------------- capture logs: index k = sample #1 after edge a+k ----------------
    logic       sdo_log [96];
    logic       cs_log  [96];
    logic       rv_log  [96];
    logic       sr_log  [96];
    logic       er_log  [96];
    logic       rr_log  [96];
    logic [7:0] rd_log  [96];

    task automatic issue(input logic w, input logic [4:0] ad, input logic [7:0] wd);
        int n = 0;
        req_valid = 1'b1; req_write = w; req_addr = ad; req_wdata = wd;
        while (req_ready !== 1'b1 && n < 100) begin @(posedge clk); #1; n++; end
        checks++;
        if (req_ready !== 1'b1) begin
            failures++;
            $display("FAIL accept_wait: req_ready=%b after %0d cycles, required 1", req_ready, n);
        end
        @(posedge clk); #1;
        req_valid = 1'b0; req_write = ~w; req_addr = ~ad; req_wdata = ~wd;
    endtask

    task automatic capture(input int n);
        for (int k = 0; k < n; k++) begin
            if (k > 0) begin @(posedge clk); #1; end
            sdo_log[k] = sdo; cs_log[k] = cs_n; rv_log[k] = rsp_valid; sr_log[k] = s_rst;
            er_log[k] = rsp_err; rr_log[k] = req_ready; rd_log[k] = rsp_rdata;
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({cs_n, sdo, s_rst, req_ready, rsp_valid, rsp_err} !== 6'b101000) begin
            failures++;
            $display("FAIL reset_outputs: got %b required 101000", {cs_n, sdo, s_rst, req_ready, rsp_valid, rsp_err});
        end
        checks++;
        if (rsp_rdata !== 8'h00) begin
            failures++; $display("FAIL reset_rdata: got %h required 00", rsp_rdata);
        end
        reset = 1'b0;
        @(posedge clk); #1;
        checks++;
        if ({s_rst, req_ready, dbg_state} !== 5'b01000) begin
            failures++; $display("FAIL reset_release: got %b required 01000", {s_rst, req_ready, dbg_state});
        end
    endtask

    task automatic test_write_frame();
        logic [17:0] obs;
        logic [17:0] cs_obs;
        issue(1'b1, 5'd5, 8'hA5);
        capture(22);
        for (int k = 0; k < 18; k++) begin obs[k] = sdo_log[k]; cs_obs[k] = cs_log[k]; end
        checks++;
        if (obs !== {16'hA505, 2'b11}) begin
            failures++; $display("FAIL write_sdo_frame: got %h required %h", obs, {16'hA505, 2'b11});
        end
        checks++;
        if (cs_obs !== 18'h0 || cs_log[18] !== 1'b1 || sdo_log[18] !== 1'b0) begin
            failures++; $display("FAIL write_cs_n: got %h/%b/%b required 0/1/0", cs_obs, cs_log[18], sdo_log[18]);
        end
        checks++;
        if ({rv_log[21], rv_log[20], rv_log[19]} !== 3'b010) begin
            failures++; $display("FAIL write_rsp_latency: got %b required 010", {rv_log[21], rv_log[20], rv_log[19]});
        end
        checks++;
        if ({er_log[20], rd_log[20], rr_log[20]} !== {1'b0, 8'h00, 1'b1}) begin
            failures++; $display("FAIL write_rsp_fields: err=%b rdata=%h ready=%b required 0 00 1", er_log[20], rd_log[20], rr_log[20]);
        end
    endtask

    task automatic test_write_read();
        logic [9:0] obs;
        issue(1'b0, 5'd5, 8'h00);
        capture(24);
        for (int k = 0; k < 10; k++) obs[k] = sdo_log[k];
        checks++;
        if (obs !== {8'h05, 2'b00} || cs_log[10] !== 1'b1) begin
            failures++; $display("FAIL read_sdo_frame: got %h cs=%b required %h cs=1", obs, cs_log[10], {8'h05, 2'b00});
        end
        checks++;
        if ({sr_log[21], sr_log[20], sr_log[19]} !== 3'b010) begin
            failures++; $display("FAIL read_s_rst_pulse: got %b required 010", {sr_log[21], sr_log[20], sr_log[19]});
        end
        checks++;
        if ({rv_log[22], rv_log[21], rv_log[20]} !== 3'b010) begin
            failures++; $display("FAIL read_rsp_latency: got %b required 010", {rv_log[22], rv_log[21], rv_log[20]});
        end
        checks++;
        if (rd_log[21] !== 8'hA5 || er_log[21] !== 1'b0) begin
            failures++; $display("FAIL read_rdata: got %h err=%b required a5 err=0", rd_log[21], er_log[21]);
        end
        checks++;
        if (rd_log[23] !== 8'hA5) begin
            failures++; $display("FAIL read_rdata_hold: got %h required a5", rd_log[23]);
        end
    endtask

    task automatic test_addr_edges();
        logic [17:0] wobs;
        logic [9:0]  robs;
        issue(1'b1, 5'd0, 8'h3C);
        capture(22);
        checks++;
        if (rv_log[20] !== 1'b1) begin
            failures++; $display("FAIL addr0_write_rsp: got %b required 1", rv_log[20]);
        end
        issue(1'b1, 5'd31, 8'hC3);
        capture(22);
        for (int k = 0; k < 18; k++) wobs[k] = sdo_log[k];
        checks++;
        if (wobs !== {8'hC3, 3'b000, 5'd31, 2'b11}) begin
            failures++; $display("FAIL addr31_write_frame: got %h required %h", wobs, {8'hC3, 3'b000, 5'd31, 2'b11});
        end
        issue(1'b0, 5'd0, 8'h00);
        capture(22);
        checks++;
        if (rd_log[21] !== 8'h3C || rv_log[21] !== 1'b1) begin
            failures++; $display("FAIL addr0_read: got %h valid=%b required 3c valid=1", rd_log[21], rv_log[21]);
        end
        issue(1'b0, 5'd31, 8'h00);
        capture(22);
        for (int k = 0; k < 10; k++) robs[k] = sdo_log[k];
        checks++;
        if (robs !== {8'h1F, 2'b00}) begin
            failures++; $display("FAIL addr31_read_frame: got %h required %h", robs, {8'h1F, 2'b00});
        end
        checks++;
        if (rd_log[21] !== 8'hC3) begin
            failures++; $display("FAIL addr31_read: got %h required c3", rd_log[21]);
        end
    endtask

    task automatic test_back_to_back();
        issue(1'b1, 5'd7, 8'h77);
        capture(20);
        req_valid = 1'b1; req_write = 1'b0; req_addr = 5'd7; req_wdata = 8'h00;
        @(posedge clk); #1;
        checks++;
        if ({rsp_valid, req_ready, rsp_err} !== 3'b110) begin
            failures++; $display("FAIL b2b_rsp_cycle: got %b required 110", {rsp_valid, req_ready, rsp_err});
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
        checks++;
        if ({cs_n, sdo, rsp_valid, req_ready} !== 4'b0000) begin
            failures++; $display("FAIL b2b_accept: got %b required 0000", {cs_n, sdo, rsp_valid, req_ready});
        end
        capture(22);
        checks++;
        if (rd_log[21] !== 8'h77 || rv_log[21] !== 1'b1) begin
            failures++; $display("FAIL b2b_read: got %h valid=%b required 77 valid=1", rd_log[21], rv_log[21]);
        end
    endtask

    task automatic test_reset_mid();
        logic any_rv;
        issue(1'b1, 5'd9, 8'hFF);
        capture(9);
        reset = 1'b1;
        @(posedge clk); #1;
        checks++;
        if ({cs_n, s_rst, rsp_valid, req_ready} !== 4'b1100) begin
            failures++; $display("FAIL midreset_outputs: got %b required 1100", {cs_n, s_rst, rsp_valid, req_ready});
        end
        reset = 1'b0;
        capture(30);
        any_rv = 1'b0;
        for (int k = 0; k < 30; k++) any_rv |= rv_log[k];
        checks++;
        if (any_rv !== 1'b0) begin
            failures++; $display("FAIL midreset_no_rsp: got %b required 0", any_rv);
        end
        issue(1'b0, 5'd9, 8'h00);
        capture(22);
        checks++;
        if (rd_log[21] !== 8'h53) begin
            failures++; $display("FAIL midreset_content: got %h required 53", rd_log[21]);
        end
    endtask

    task automatic test_timeout();
        stub_done = 1'b1;
        issue(1'b1, 5'd2, 8'h11);
`ifdef SPI_MEM_CTRL_TIMEOUT_EN
        // WAIT entered after edge a+18, so the abort strobe is due after a+18+32+1
        capture(53);
        checks++;
        if ({rv_log[52], rv_log[51], rv_log[50], rv_log[20]} !== 4'b0100) begin
            failures++; $display("FAIL timeout_latency: got %b required 0100", {rv_log[52], rv_log[51], rv_log[50], rv_log[20]});
        end
        checks++;
        if ({sr_log[51], sr_log[50], sr_log[49]} !== 3'b010) begin
            failures++; $display("FAIL timeout_s_rst: got %b required 010", {sr_log[51], sr_log[50], sr_log[49]});
        end
        checks++;
        if (er_log[51] !== 1'b1 || rd_log[51] !== 8'h00) begin
            failures++; $display("FAIL timeout_fields: err=%b rdata=%h required 1 00", er_log[51], rd_log[51]);
        end
        stub_done = 1'b0;
`else
        begin
            logic any_rv;
            capture(90);
            any_rv = 1'b0;
            for (int k = 0; k < 90; k++) any_rv |= rv_log[k];
            checks++;
            if (any_rv !== 1'b0 || dbg_state !== 3'd3) begin
                failures++; $display("FAIL wait_stall: rsp_seen=%b state=%0d required 0 and 3", any_rv, dbg_state);
            end
            stub_done = 1'b0;
            reset = 1'b1;
            repeat (2) @(posedge clk);
            #1;
            reset = 1'b0;
        end
`endif
    endtask

    initial begin
        test_reset();
        test_write_frame();
        test_write_read();
        test_addr_edges();
        test_back_to_back();
        test_reset_mid();
        test_timeout();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/spi_mem_ctrl.md
# spi_mem_ctrl

Host-side SPI master that sits directly upstream of the team's SPI memory slave (32 × 8 bit). It accepts single-word read/write requests on a valid/ready host port, serialises them onto the slave link (active-low select, one data bit per clk, LSB first), and returns read data or completion on a one-cycle response strobe. It also owns the slave's recovery reset: the slave parks after a read until it is reset.

## Interface
- TIMEOUT, 32: cycles to wait for slave s_op_done / s_ready before aborting. Range 2–255.
- clk  in  1  clock; slave runs on the same clock
- reset  in  1  synchronous, active-high
- req_valid  in  1  host request present
- req_ready  out  1  high only in IDLE; transfer on req_valid && req_ready
- req_write  in  1  1 = write, 0 = read
- req_addr  in  5  word address; sent as 8-bit field, bits 7:5 = 0
- req_wdata  in  8  write data
- rsp_valid  out  1  one-cycle completion strobe
- rsp_rdata  out  8  read data; 0 for writes and errors; held until next rsp_valid
- rsp_err  out  1  timeout abort; qualified by rsp_valid
- cs_n  out  1  slave select, active low
- sdo  out  1  serial data to slave
- sdi  in  1  serial data from slave
- s_ready  in  1  slave read-address-received pulse
- s_op_done  in  1  slave write-complete pulse
- s_rst  out  1  slave reset; integration ORs nothing else in

## Operation
- States: IDLE, CMD, SHIFT, WAIT, CAPTURE, RECOVER. All outputs registered.
- Reset values: cs_n=1, sdo=0, s_rst=1, req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0. First edge after reset release: s_rst=0, state IDLE, req_ready=1.
- IDLE: on accept, latch frame = {wdata, 3'b0, addr} (write, 16 bits) or {3'b0, addr} (read, 8 bits); cs_n=0, sdo=req_write; go CMD.
- CMD: hold sdo=op for 2 cycles total (slave needs one cycle to see select, one to sample op), then SHIFT.
- SHIFT: sdo = frame bit, LSB first, one per cycle (16 write / 8 read). After last bit: cs_n=1, sdo=0, go WAIT.
- WAIT (write): on s_op_done=1 → rsp_valid=1, rsp_err=0, rsp_rdata=0, go IDLE.
- WAIT (read): on s_ready=1 → CAPTURE.
- CAPTURE: shift sdi into rdata LSB first, 8 cycles; then s_rst=1 one cycle → RECOVER.
- RECOVER: s_rst=0, rsp_valid=1, rsp_rdata=captured byte, go IDLE.
- cs_n is deasserted before the slave returns to idle, so the slave never re-triggers on a held select.
- Reset mid-transfer: immediate return to reset values; in-flight response dropped; s_rst=1 clears slave.
- req_valid while not IDLE: ignored (req_ready=0). Changes to req_* after accept have no effect.

## Timing
- Accept at edge a. cs_n=0 and sdo=op after a; op held through edge a+2.
- Frame bit i driven after edge a+2+i (sampled by slave at a+3+i).
- Write: last bit sampled a+18; cs_n=1 after a+18; s_op_done seen at a+20; rsp_valid high after a+20. Latency 20.
- Read: cs_n=1 after a+10; s_ready seen at a+12; sdi bit i sampled at edge a+13+i; s_rst high after a+20 for one cycle; rsp_valid high after a+21. Latency 21.
- Back-to-back: rsp_valid cycle is IDLE with req_ready=1; next accept may coincide with rsp_valid.

## Configuration
- SPI_MEM_CTRL_TIMEOUT_EN defined: 8-bit counter runs in WAIT; at TIMEOUT cycles without the expected pulse → s_rst=1 one cycle, then rsp_valid=1, rsp_err=1, rsp_rdata=0, IDLE.
- Not defined: WAIT stalls indefinitely; no counter; rsp_err tied 0.

## Test plan
- Write addr 5 data 0xA5 accepted at edge a → sdo frame 1,1,bits 0x05 then 0xA5 LSB first; rsp_valid at a+20, rsp_err=0.
- Write addr 5 0xA5 then read addr 5 → rsp_rdata=0xA5 at accept+21; s_rst one-cycle pulse at accept+20.
- Write 0x3C@0, 0xC3@31, read both → 0x3C, 0xC3; addr bits 7:5 on sdo observed 0.
- Back-to-back request held valid during rsp_valid → accepted same cycle, cs_n low next cycle.
- Reset asserted at SHIFT bit 6 of a write → cs_n=1, s_rst=1, no rsp_valid; subsequent read of that address returns pre-existing content.
- TIMEOUT_EN, s_op_done stubbed to 0 → rsp_valid with rsp_err=1 exactly TIMEOUT+1 cycles after WAIT entry; without macro, no response.
